// File: rtl/nixie_sched_pkg.sv
// Shared types and constants for the Nixie display-frame scheduler.
package nixie_sched_pkg;

  localparam int BCD_W = 32;
  localparam int DP_W  = 16;

  localparam logic [DP_W-1:0] AP_DP = 16'hFFFF;

  // Doubles as the frame_source encoding on the top-level port.
  typedef enum logic [1:0] {
    SRC_TIME = 2'd0,
    SRC_HOST = 2'd1,
    SRC_AP   = 2'd2
  } mode_t;

  function automatic logic [BCD_W-1:0] ap_pattern(input logic [3:0] digit);
    return {8{digit}};
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Brings the asynchronous PPS into clk: two synchronizer flops, one edge flop,
// and a single-cycle rise strobe.
module pps_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pps,
  output logic rise
);

  logic [2:0] stage_reg;
  logic [2:0] stage_in;

  assign stage_in = {stage_reg[1:0], pps};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_reg[gi] <= 1'b0;
        end else begin
          stage_reg[gi] <= stage_in[gi];
        end
      end
    end
  endgenerate

  // stage 0 may go metastable; only stages 1 and 2 feed logic.
  assign rise = stage_reg[1] & ~stage_reg[2];

endmodule

// File: rtl/nixie_frame_scheduler.sv
// Picks TIME / HOST / anti-poison frames for the Nixie driver, committing only
// on PPS rising edges, and counts seconds the driver failed to confirm.
module nixie_frame_scheduler
  import nixie_sched_pkg::*;
#(
  parameter int unsigned     HOLD_SECS = 5,
  parameter int unsigned     AP_ROUNDS = 1,
  parameter logic [DP_W-1:0] TIME_DP   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pps,
  input  logic [BCD_W-1:0]  time_bcd,
  input  logic [BCD_W-1:0]  host_bcd,
  input  logic [DP_W-1:0]   host_dp,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              ap_start,
  output logic              ap_busy,
  input  logic              drv_done,
  output logic [BCD_W-1:0]  NixieBCD,
  output logic [DP_W-1:0]   digitpoint,
  output logic [1:0]        frame_source,
  output logic              frame_miss,
  output logic [7:0]        miss_count
);

  localparam int HOLD_W = $clog2(HOLD_SECS + 1);
  localparam int RND_W  = (AP_ROUNDS > 1) ? $clog2(AP_ROUNDS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SECS);
  localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(AP_ROUNDS - 1);

  logic rise;

  pps_edge_sync u_pps_sync (
    .clk  (clk),
    .rst  (rst),
    .pps  (pps),
    .rise (rise)
  );

  mode_t              mode_reg, mode_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic [DP_W-1:0]    dp_reg, dp_next;
  logic               host_empty_reg, host_empty_next;
  logic [BCD_W-1:0]   buf_bcd_reg, buf_bcd_next;
  logic [DP_W-1:0]    buf_dp_reg, buf_dp_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic               ap_pending_reg, ap_pending_next;
  logic               ap_busy_reg, ap_busy_next;
  logic [3:0]         digit_reg, digit_next;
  logic [RND_W-1:0]   round_reg, round_next;
  logic               done_flag_reg, done_flag_next;
  logic               first_seen_reg, first_seen_next;
  logic               miss_reg, miss_next;
  logic [7:0]         miss_count_reg, miss_count_next;

  logic accept;
  logic ap_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg       <= SRC_TIME;
      bcd_reg        <= '0;
      dp_reg         <= '0;
      host_empty_reg <= 1'b1;
      buf_bcd_reg    <= '0;
      buf_dp_reg     <= '0;
      hold_reg       <= '0;
      ap_pending_reg <= 1'b0;
      ap_busy_reg    <= 1'b0;
      digit_reg      <= '0;
      round_reg      <= '0;
      done_flag_reg  <= 1'b0;
      first_seen_reg <= 1'b0;
      miss_reg       <= 1'b0;
      miss_count_reg <= '0;
    end else begin
      mode_reg       <= mode_next;
      bcd_reg        <= bcd_next;
      dp_reg         <= dp_next;
      host_empty_reg <= host_empty_next;
      buf_bcd_reg    <= buf_bcd_next;
      buf_dp_reg     <= buf_dp_next;
      hold_reg       <= hold_next;
      ap_pending_reg <= ap_pending_next;
      ap_busy_reg    <= ap_busy_next;
      digit_reg      <= digit_next;
      round_reg      <= round_next;
      done_flag_reg  <= done_flag_next;
      first_seen_reg <= first_seen_next;
      miss_reg       <= miss_next;
      miss_count_reg <= miss_count_next;
    end
  end

  assign accept  = host_valid & host_empty_reg;
  assign ap_last = (mode_reg == SRC_AP) && (digit_reg == 4'd9) && (round_reg == RND_LAST);

  always_comb begin
    mode_next       = mode_reg;
    bcd_next        = bcd_reg;
    dp_next         = dp_reg;
    host_empty_next = host_empty_reg;
    buf_bcd_next    = buf_bcd_reg;
    buf_dp_next     = buf_dp_reg;
    hold_next       = hold_reg;
    ap_pending_next = ap_pending_reg;
    ap_busy_next    = ap_busy_reg;
    digit_next      = digit_reg;
    round_next      = round_reg;
    done_flag_next  = done_flag_reg | drv_done;
    first_seen_next = first_seen_reg;
    miss_next       = 1'b0;
    miss_count_next = miss_count_reg;

    if (accept) begin
      host_empty_next = 1'b0;
      buf_bcd_next    = host_bcd;
      buf_dp_next     = host_dp;
    end

    if (ap_start && !ap_busy_reg && !ap_pending_reg) begin
      ap_pending_next = 1'b1;
    end

    if (rise) begin
      // drv_done seen in the rise cycle belongs to the second just starting.
      done_flag_next = drv_done;
      if (!first_seen_reg) begin
        first_seen_next = 1'b1;
      end else if (!done_flag_reg) begin
        miss_next = 1'b1;
        if (miss_count_reg != 8'hFF) begin
          miss_count_next = miss_count_reg + 8'd1;
        end
      end

      // Decisions use state from before this cycle, so same-cycle requests
      // wait for the following boundary.
      if (mode_reg == SRC_AP && !ap_last) begin
        if (digit_reg == 4'd9) begin
          digit_next = 4'd0;
          round_next = round_reg + RND_W'(1);
        end else begin
          digit_next = digit_reg + 4'd1;
        end
        bcd_next = ap_pattern(digit_next);
        dp_next  = AP_DP;
      end else if (ap_pending_reg) begin
        mode_next       = SRC_AP;
        digit_next      = 4'd0;
        round_next      = '0;
        ap_pending_next = 1'b0;
        ap_busy_next    = 1'b1;
        hold_next       = '0;
        bcd_next        = ap_pattern(4'd0);
        dp_next         = AP_DP;
      end else if (!host_empty_reg) begin
        mode_next       = SRC_HOST;
        bcd_next        = buf_bcd_reg;
        dp_next         = buf_dp_reg;
        host_empty_next = 1'b1;
        hold_next       = HOLD_LOAD;
        ap_busy_next    = 1'b0;
      end else if (mode_reg == SRC_HOST && hold_reg > HOLD_W'(1)) begin
        hold_next = hold_reg - HOLD_W'(1);
      end else begin
        mode_next    = SRC_TIME;
        bcd_next     = time_bcd;
        dp_next      = TIME_DP;
        hold_next    = '0;
        ap_busy_next = 1'b0;
      end
    end
  end

  assign host_ready   = host_empty_reg;
  assign ap_busy      = ap_busy_reg;
  assign NixieBCD     = bcd_reg;
  assign digitpoint   = dp_reg;
  assign frame_source = mode_reg;
  assign frame_miss   = miss_reg;
  assign miss_count   = miss_count_reg;

endmodule

// File: doc/nixie_frame_scheduler.md
# nixie_frame_scheduler

Display-frame controller sitting upstream of the Nixie shift-register driver (`NixieCounter`). It owns the driver's `NixieBCD`/`digitpoint` inputs and chooses among three requesters: live time from timekeeping, host frames from the Pi, and a cathode anti-poisoning sweep. It commits a new frame only on a PPS rising edge, so the frame is stable when the driver samples on the PPS falling edge. It also monitors the driver's `Done` to flag missed frames.

## Interface
- `HOLD_SECS`, 5: PPS seconds a host frame stays displayed after it is committed (≥1).
- `AP_ROUNDS`, 1: number of 0→9 sweeps per anti-poison run (≥1).
- `TIME_DP`, 16'h0000: `digitpoint` value while showing time.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pps` in 1: asynchronous PPS from GPS.
- `time_bcd` in 32: 8 BCD digits of current time, continuously valid.
- `host_bcd` in 32, `host_dp` in 16: host frame payload.
- `host_valid` in 1 / `host_ready` out 1: host frame handshake.
- `ap_start` in 1: one-cycle request for an anti-poison run.
- `ap_busy` out 1: high while an anti-poison run is displayed.
- `drv_done` in 1: driver `Done`.
- `NixieBCD` out 32, `digitpoint` out 16: frame to the driver.
- `frame_source` out 2: 0 = TIME, 1 = HOST, 2 = AP.
- `frame_miss` out 1: one-cycle pulse when a frame was not confirmed.
- `miss_count` out 8: saturating count of `frame_miss` pulses.

## Operation
- `pps` passes through a 2-flop synchronizer and then an edge register. `rise` = sync1 & ~sync2.
- Mode FSM has states TIME, HOST and AP. Transitions happen only in a `rise` cycle. Priority at each boundary: AP pending > HOST pending > current HOST hold > TIME.
- **TIME:**
  - `NixieBCD` ← `time_bcd` at every `rise`.
  - `digitpoint` ← `TIME_DP`.
- **Host handshake:**
  - `host_ready` = buffer empty.
  - Accept when `host_valid & host_ready`. This captures `host_bcd`/`host_dp` into the pending buffer, and `host_ready` drops the next cycle.
- **HOST:**
  - At `rise` with a pending host frame and no pending AP: display the buffer, free it (`host_ready` high next cycle), and load `hold` = `HOLD_SECS`.
  - Each later `rise` decrements `hold`. When `hold` reaches 0, return to TIME at that boundary.
  - A new host frame committed while in HOST replaces the display and restarts `hold`.
- **AP:**
  - `ap_start` sets `ap_pending`. It is ignored while `ap_busy` or `ap_pending` is already set.
  - At `rise` with `ap_pending`: enter AP, digit `d` = 0, round = 0, clear `ap_pending`, set `ap_busy`.
  - Display `NixieBCD` = {8{d}} and `digitpoint` = 16'hFFFF.
  - Each `rise` increments `d`; 9→0 increments round.
  - After `d` = 9 of the last round has been shown for one second, the next `rise` exits. It goes to HOST if a host frame is pending, else TIME, in that same boundary. `ap_busy` falls with the exit.
  - An AP entered from HOST abandons the remaining `hold`.
- **Miss monitor:**
  - A flag is set by `drv_done` = 1 and cleared at each `rise`.
  - At a `rise` with the flag clear, pulse `frame_miss` and increment `miss_count`, saturating at 255.
  - The first `rise` after reset is exempt.

## Timing
- Reset values:
  - `NixieBCD` = 0, `digitpoint` = 0, `frame_source` = 0.
  - `host_ready` = 1, `ap_busy` = 0, `frame_miss` = 0, `miss_count` = 0.
  - Buffer empty, `ap_pending` = 0, mode TIME, `d` = 0.
- PPS latency: `pps` first sampled high at edge E0, giving `rise` after E1. Outputs (`NixieBCD`, `digitpoint`, `frame_source`, `ap_busy`, `frame_miss`) update at E2. All outputs are registered.
- Outputs are constant between `rise` cycles. `time_bcd` changes between rises are not visible.
- Same-cycle events:
  - Host accept or `ap_start` in a `rise` cycle is served at the following `rise`, not the current one.
  - `drv_done` in a `rise` cycle counts for the new interval.
- Host frame pending during AP: `host_ready` stays 0 until the AP exit commits the frame.
- `rst` mid-operation returns every register to its reset value on the next edge and aborts AP/HOST. A `pps` already in the synchronizer may produce a `rise` after reset; that rise is the exempt first rise.

## Structure
- Package `nixie_sched_pkg` holds:
  - The mode/`frame_source` enum (TIME = 0, HOST = 1, AP = 2).
  - The `AP_DP` = 16'hFFFF constant.
  - Width constants for BCD (32) and DP (16).
- Sub-module `pps_edge_sync`: 2-flop synchronizer plus rise detect, with the same `clk`/`rst`. Everything else is one FSM module.

## Test plan
- Reset, `time_bcd` = 32'h12345678, 3 PPS with `drv_done` pulsed each second:
  - `NixieBCD` = 32'h12345678 at E2 after the first rise.
  - `frame_source` = 0, `frame_miss` never.
- Host frame 32'h00000042 / 16'h0003 accepted mid-second, `HOLD_SECS` = 5:
  - `host_ready` 0 until the next rise, then HOST for 5 rises, then TIME at the 6th.
- `ap_start`, `AP_ROUNDS` = 1:
  - Displays 32'h00000000, 32'h11111111, … 32'h99999999 on consecutive rises, `digitpoint` 16'hFFFF, `ap_busy` high for 10 seconds.
  - Then TIME.
- Host frame accepted during AP:
  - `host_ready` stays 0 through the sweep.
  - The frame shows immediately after the 9s second, with `frame_source` = 1.
- `drv_done` held 0 for 300 seconds:
  - `frame_miss` pulses from the 2nd rise on, and `miss_count` saturates at 255.
  - `rst` mid-AP returns all outputs to reset values on the next edge.
